cpu_ctrl: RTL and testbench
===========================

# cpu_ctrl

Instruction register, decoder and control FSM sitting directly upstream of the register-file/ALU datapath. It latches a 16-bit instruction, then sequences the datapath's select, load and write strobes over several cycles to run MOV, ADD, CMP, AND, MVN and HALT. It also supplies the sign-extended immediate on the datapath's external data input. The block asserts `w` when idle and ready for a new instruction.

## Interface
- No parameters. Widths are fixed by the datapath: 16-bit data, 3-bit register index, 2-bit shift and ALU op.
- `clk` in 1: the single clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in` in 16: instruction word.
- `load` in 1: capture `in` into the IR. Honoured only when `w`=1.
- `s` in 1: start execution of the IR. Honoured only when `w`=1.
- `w` out 1: idle/ready.
- `datapath_in` out 16: sign-extended immediate; drives the datapath external input.
- `asel`, `bsel`, `vsel` out 1 each: datapath operand and writeback selects.
- `loada`, `loadb`, `loadc`, `loads`, `write` out 1 each: datapath strobes.
- `readnum`, `writenum` out 3 each: register indices.
- `shift`, `ALUop` out 2 each: shifter and ALU controls.

## Operation
Instruction fields:
- `op3` = IR[15:13]
- `op2` = IR[12:11]
- Rn = IR[10:8]
- Rd = IR[7:5]
- sh = IR[4:3]
- Rm = IR[2:0]
- imm8 = IR[7:0]

Decoded instructions:
- 110/10 MOV Rn,#imm8: `datapath_in` = sign-extended imm8.
- 110/00 MOV Rd,Rm{,sh}.
- 101/00 ADD Rd,Rn,Rm{,sh}.
- 101/01 CMP Rn,Rm{,sh}.
- 101/10 AND Rd,Rn,Rm{,sh}.
- 101/11 MVN Rd,Rm{,sh}.
- 111/xx HALT.
- Any other encoding is a no-op: DECODE goes straight to WAIT.

FSM states and transitions:
- WAIT: `w`=1. Goes to DECODE when `s`=1.
- DECODE: MOV imm goes to WIMM; MOV reg and MVN go to GETB; ADD, AND and CMP go to GETA; HALT goes to HALT.
- GETA: `readnum`=Rn, `loada`=1. Goes to GETB.
- GETB: `readnum`=Rm, `loadb`=1. Goes to ALU.
- ALU: `loadc`=1, with `loads`=1 only for CMP. `ALUop` = `op2` for 101 instructions and 00 for MOV reg. `asel`=1 (A=0) for MOV reg and MVN, otherwise 0. CMP goes to WAIT; all other instructions go to WREG.
- WREG: `writenum`=Rd, `vsel`=0, `write`=1. Goes to WAIT.
- WIMM: `writenum`=Rn, `vsel`=1, `write`=1. Goes to WAIT.
- HALT: `w`=0, all strobes 0. Exits only on reset.

Output rules:
- `shift` = sh in every state.
- `bsel`=0 always; it is reserved for a future immediate-ALU form.
- Outputs are Moore-style (state plus IR fields). Every strobe is 0 outside the states listed above.
- `readnum`/`writenum` are 0 when not in use.
- `datapath_in` is combinational from the IR. It is sign-extended imm8 for every encoding.

## Timing
Reset:
- `rst_n`=0 immediately forces state WAIT and IR=0.
- All outputs go to 0 except `w`=1, because IR=0 also gives `datapath_in`=0.
- Reset mid-instruction abandons the instruction. No `write` pulse may follow the reset.

Latency:
- The edge that samples `s`=1 in WAIT enters DECODE.
- Cycles spent outside WAIT: MOV imm 2, MOV reg/MVN 4, CMP 4, ADD/AND 5.
- `w` returns to 1 on the edge after the last state.

Boundary conditions:
- `s` and `load` high in the same WAIT cycle: the IR loads on that edge and DECODE sees the new IR.
- `load` or `s` while `w`=0: ignored, and the IR is unchanged during execution.
- `s` held high: the next instruction begins immediately on return to WAIT.

## Structure
- Package `ctrl_pkg` holds:
  - state enum WAIT/DECODE/GETA/GETB/ALU/WREG/WIMM/HALT;
  - `op3` constants OP_MOV=3'b110, OP_ALU=3'b101, OP_HALT=3'b111;
  - ALU op constants ADD/CMP/AND/MVN = 00/01/10/11.
- One combinational sub-module `instr_dec` takes the IR and produces the fields, the sign-extended immediate and the instruction class.
- The FSM and IR stay in `cpu_ctrl`.

## Test plan
- Reset:
  - Stimulus: `rst_n` low, then load 0xD007, pulse `s`.
  - Required: in WIMM, `writenum`=0, `vsel`=1, `write`=1, `datapath_in`=0x0007; `w`=1 two edges after DECODE entry.
- MOV negative immediate:
  - Stimulus: load 0xD1FE, pulse `s`.
  - Required: `datapath_in`=0xFFFE, `writenum`=1.
- ADD with shift:
  - Stimulus: load 0xA148 (ADD R2,R1,R0 LSL), pulse `s`.
  - Required, one state per cycle:
    - GETA: `readnum`=1, `loada`=1.
    - GETB: `readnum`=0, `loadb`=1, `shift`=01.
    - ALU: `asel`=0, `ALUop`=00, `loadc`=1.
    - WREG: `writenum`=2, `write`=1.
- CMP and MVN:
  - 0xA900 (CMP): `loads`=1 in ALU and no `write` pulse.
  - 0xB860 (MVN): skips GETA; `asel`=1, `ALUop`=11; writes R3.
- HALT:
  - Stimulus: load 0xE000, pulse `s`.
  - Required: `w` stays 0 indefinitely and `load`/`s` are ignored; after `rst_n` pulse, `w`=1.
- Reset mid-op:
  - Stimulus: drop `rst_n` during GETB of ADD.
  - Required: all strobes 0 at once, `w`=1, no `write` afterward.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the instruction controller.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_WAIT, ST_DECODE, ST_GETA, ST_GETB, ST_ALU, ST_WREG, ST_WIMM, ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CL_NOP, CL_MOV_IMM, CL_MOV_REG, CL_ALU, CL_HALT
    } iclass_t;

    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_ALU  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] MOV_IMM = 2'b10;
    localparam logic [1:0] MOV_REG = 2'b00;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/cpu_ctrl_instr_dec.sv
// Splits the instruction register into fields and classifies the instruction.
module instr_dec
    import ctrl_pkg::*;
(
    input  logic [15:0] ir,
    output logic [1:0]  op2,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [1:0]  sh,
    output logic [2:0]  rm,
    output logic [15:0] imm,
    output iclass_t     iclass
);

    logic [2:0] op3;

    assign op3 = ir[15:13];
    assign op2 = ir[12:11];
    assign rn  = ir[10:8];
    assign rd  = ir[7:5];
    assign sh  = ir[4:3];
    assign rm  = ir[2:0];
    assign imm = sext8(ir[7:0]);

    always_comb begin
        iclass = CL_NOP;
        case (op3)
            OP_MOV: begin
                if (op2 == MOV_IMM)
                    iclass = CL_MOV_IMM;
                else if (op2 == MOV_REG)
                    iclass = CL_MOV_REG;
            end
            OP_ALU:  iclass = CL_ALU;
            OP_HALT: iclass = CL_HALT;
            default: iclass = CL_NOP;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Instruction register and multi-cycle control FSM driving the regfile/ALU datapath.
//   state  | meaning
//   WAIT   | idle, w=1, IR may load
//   DECODE | choose path from instruction class
//   GETA   | read Rn into A
//   GETB   | read Rm into B
//   ALU    | latch result into C (and status for CMP)
//   WREG   | write C to Rd
//   WIMM   | write immediate to Rn
//   HALT   | stopped until reset
module cpu_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [15:0] datapath_in,
    output logic        asel,
    output logic        bsel,
    output logic        vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop
);

    state_t     state, state_next;
    logic [15:0] ir;
    logic [1:0]  op2;
    logic [2:0]  rn, rd, rm;
    logic [1:0]  sh;
    iclass_t     iclass;

    instr_dec u_dec (
        .ir     (ir),
        .op2    (op2),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .imm    (datapath_in),
        .iclass (iclass)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ir <= '0;
        else if (w && load)
            ir <= in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_WAIT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        w          = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        vsel       = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        write      = 1'b0;
        readnum    = 3'd0;
        writenum   = 3'd0;
        ALUop      = 2'b00;
        shift      = sh;
        case (state)
            ST_WAIT: begin
                w = 1'b1;
                if (s)
                    state_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (iclass)
                    CL_MOV_IMM: state_next = ST_WIMM;
                    CL_MOV_REG: state_next = ST_GETB;
                    CL_ALU:     state_next = (op2 == ALU_MVN) ? ST_GETB : ST_GETA;
                    CL_HALT:    state_next = ST_HALT;
                    default:    state_next = ST_WAIT;
                endcase
            end
            ST_GETA: begin
                readnum    = rn;
                loada      = 1'b1;
                state_next = ST_GETB;
            end
            ST_GETB: begin
                readnum    = rm;
                loadb      = 1'b1;
                state_next = ST_ALU;
            end
            ST_ALU: begin
                loadc = 1'b1;
                // MOV reg and MVN force A to zero so B passes straight through
                if (iclass == CL_ALU) begin
                    ALUop      = op2;
                    loads      = (op2 == ALU_CMP);
                    asel       = (op2 == ALU_MVN);
                    state_next = (op2 == ALU_CMP) ? ST_WAIT : ST_WREG;
                end else begin
                    asel       = 1'b1;
                    state_next = ST_WREG;
                end
            end
            ST_WREG: begin
                writenum   = rd;
                write      = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WIMM: begin
                writenum   = rn;
                vsel       = 1'b1;
                write      = 1'b1;
                state_next = ST_WAIT;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_WAIT;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl with an instruction-level reference model.
module tb_cpu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_w = '0;
    logic        load = 1'b0;
    logic        s = 1'b0;
    logic        w, asel, bsel, vsel, loada, loadb, loadc, loads, write;
    logic [15:0] datapath_in;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, alu_op;

    int errors = 0;
    int checks = 0;

    cpu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in(in_w), .load(load), .s(s), .w(w),
        .datapath_in(datapath_in), .asel(asel), .bsel(bsel), .vsel(vsel),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .write(write),
        .readnum(readnum), .writenum(writenum), .shift(shift), .ALUop(alu_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       w, asel, bsel, vsel, loada, loadb, loadc, loads, write;
        logic [2:0] readnum, writenum;
        logic [1:0] shift, aluop;
        logic [15:0] dp;
    } obs_t;

    obs_t act;
    always_comb act = {w, asel, bsel, vsel, loada, loadb, loadc, loads, write,
                       readnum, writenum, shift, alu_op, datapath_in};

    // Reference model: per-cycle expected outputs for the instruction in flight
    obs_t        q[$];
    logic [15:0] mir = '0;
    bit          mhalt = 1'b0;

    function automatic obs_t base(input logic [15:0] ir, input logic wv);
        obs_t o = '0;
        o.w     = wv;
        o.shift = ir[4:3];
        o.dp    = {{8{ir[7]}}, ir[7:0]};
        return o;
    endfunction

    function automatic obs_t exp_now();
        if (q.size() > 0) return q[0];
        return base(mir, !mhalt);
    endfunction

    task automatic plan(input logic [15:0] ir);
        obs_t d;
        logic [2:0] op3 = ir[15:13];
        logic [1:0] op2 = ir[12:11];
        q.push_back(base(ir, 1'b0));
        if (op3 == 3'b110 && op2 == 2'b10) begin
            d = base(ir, 1'b0); d.writenum = ir[10:8]; d.vsel = 1'b1; d.write = 1'b1;
            q.push_back(d);
        end else if ((op3 == 3'b110 && op2 == 2'b00) || op3 == 3'b101) begin
            if (op3 == 3'b101 && op2 != 2'b11) begin
                d = base(ir, 1'b0); d.readnum = ir[10:8]; d.loada = 1'b1;
                q.push_back(d);
            end
            d = base(ir, 1'b0); d.readnum = ir[2:0]; d.loadb = 1'b1;
            q.push_back(d);
            d = base(ir, 1'b0); d.loadc = 1'b1;
            if (op3 == 3'b101) begin
                d.aluop = op2;
                d.loads = (op2 == 2'b01);
                d.asel  = (op2 == 2'b11);
            end else begin
                d.asel = 1'b1;
            end
            q.push_back(d);
            if (!(op3 == 3'b101 && op2 == 2'b01)) begin
                d = base(ir, 1'b0); d.writenum = ir[7:5]; d.write = 1'b1;
                q.push_back(d);
            end
        end else if (op3 == 3'b111) begin
            mhalt = 1'b1;
        end
    endtask

    task automatic model_loop();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                mir   = '0;
                mhalt = 1'b0;
            end else if (q.size() > 0) begin
                void'(q.pop_front());
            end else if (!mhalt) begin
                if (load) mir = in_w;
                if (s) plan(mir);
            end
        end
    endtask

    task automatic chk(input string name, input logic [34:0] a, input logic [34:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            chk("cycle", act, exp_now());
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] v, input bit same);
        in_w = v;
        if (same) begin
            load = 1'b1; s = 1'b1; step(); load = 1'b0; s = 1'b0;
        end else begin
            load = 1'b1; step(); load = 1'b0;
            s = 1'b1; step(); s = 1'b0;
        end
    endtask

    task automatic wait_w(input int budget);
        int n = 0;
        while (w !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("wait_w_timeout", w, 1'b1);
    endtask

    initial begin
        fork
            model_loop();
            monitor_loop();
        join_none

        step(); step();
        chk("rst_w", w, 1'b1);
        chk("rst_dp", datapath_in, 16'h0000);
        chk("rst_write", write, 1'b0);
        rst_n = 1'b1;
        step();

        // MOV R0,#7
        issue(16'hD007, 1'b0);
        chk("dec_w", w, 1'b0);
        step();
        chk("wimm_writenum", writenum, 3'd0);
        chk("wimm_vsel", vsel, 1'b1);
        chk("wimm_write", write, 1'b1);
        chk("wimm_dp", datapath_in, 16'h0007);
        step();
        chk("mov_done_w", w, 1'b1);

        // MOV R1,#-2 with load and s together
        issue(16'hD1FE, 1'b1);
        step();
        chk("movneg_dp", datapath_in, 16'hFFFE);
        chk("movneg_writenum", writenum, 3'd1);
        step();

        // ADD R2,R1,R0 LSL; load attempt mid-op must be ignored
        issue(16'hA148, 1'b0);
        step();
        load = 1'b1; in_w = 16'h1234;
        chk("add_geta_readnum", readnum, 3'd1);
        chk("add_geta_loada", loada, 1'b1);
        step();
        chk("add_getb_readnum", readnum, 3'd0);
        chk("add_getb_loadb", loadb, 1'b1);
        chk("add_getb_shift", shift, 2'b01);
        step();
        chk("add_alu_asel", asel, 1'b0);
        chk("add_alu_aluop", alu_op, 2'b00);
        chk("add_alu_loadc", loadc, 1'b1);
        step();
        load = 1'b0;
        chk("add_wreg_writenum", writenum, 3'd2);
        chk("add_wreg_write", write, 1'b1);
        chk("add_ir_kept", datapath_in, 16'h0048);
        step();
        chk("add_done_w", w, 1'b1);

        // CMP R1,R0
        issue(16'hA900, 1'b0);
        step(); step(); step();
        chk("cmp_loads", loads, 1'b1);
        chk("cmp_aluop", alu_op, 2'b01);
        step();
        chk("cmp_done_w", w, 1'b1);
        chk("cmp_no_write", write, 1'b0);

        // MVN R3,R0
        issue(16'hB860, 1'b1);
        step();
        chk("mvn_getb_loadb", loadb, 1'b1);
        chk("mvn_skip_geta", loada, 1'b0);
        step();
        chk("mvn_asel", asel, 1'b1);
        chk("mvn_aluop", alu_op, 2'b11);
        step();
        chk("mvn_writenum", writenum, 3'd3);
        step();
        chk("mvn_done_w", w, 1'b1);

        // Unused encoding: straight back to WAIT
        issue(16'h0000, 1'b1);
        step();
        chk("nop_w", w, 1'b1);

        // s held high: next instruction starts on return to WAIT
        in_w = 16'hD007; load = 1'b1; s = 1'b1;
        step();
        load = 1'b0;
        step();
        step();
        chk("held_s_wait", w, 1'b1);
        step();
        chk("held_s_restart", w, 1'b0);
        s = 1'b0;
        wait_w(10);

        // HALT ignores load and s until reset
        issue(16'hE000, 1'b0);
        in_w = 16'hD1FE; load = 1'b1; s = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("halt_w", w, 1'b0);
        end
        load = 1'b0; s = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("halt_rst_w", w, 1'b1);
        step();
        rst_n = 1'b1;
        step();
        chk("halt_rst_dp", datapath_in, 16'h0000);

        // Reset during GETB of ADD
        issue(16'hA148, 1'b0);
        step(); step();
        chk("midop_getb", loadb, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midop_loadb", loadb, 1'b0);
        chk("midop_w", w, 1'b1);
        chk("midop_readnum", readnum, 3'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("midop_no_write", write, 1'b0);
        end
        chk("midop_end_w", w, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
